fb_draw_engine: RTL

- Write-side producer for the double-buffered SPRAM framebuffer; replaces the free-running wx/wy/colour counter.
- On each frame switch, clears the back buffer to a background colour, then rasterises queued solid-rectangle commands.
- Emits one framebuffer write per pixel_clk, so its outputs connect straight to the framebuffer write port (we/wx/wy/wc).
- Runs in the pixel_clk domain. Its new_frame input is the same strobe that drives switch_buffers.

---
 rtl/fb_draw_pkg.sv | 24 ++
 rtl/fb_draw_engine_raster.sv | 57 +++++
 rtl/fb_draw_engine.sv | 107 ++++++++++
 3 files changed

// File: rtl/fb_draw_pkg.sv
// Shared types and default geometry for the framebuffer draw engine.
// Rectangle commands and engine states live here.
package fb_draw_pkg;

  localparam int FB_X_W = 8;
  localparam int FB_Y_W = 7;
  localparam int FB_C_W = 12;

  typedef enum logic [1:0] {
    S_WAIT_FRAME,
    S_CLEAR,
    S_IDLE,
    S_FILL
  } state_t;

  typedef struct packed {
    logic [FB_X_W-1:0] x0;
    logic [FB_Y_W-1:0] y0;
    logic [FB_X_W-1:0] x1;
    logic [FB_Y_W-1:0] y1;
    logic [FB_C_W-1:0] color;
  } rect_cmd_t;

endpackage

// File: rtl/fb_draw_engine_raster.sv
// Loadable row-major x/y scan counter, shared by clear and fill.
// x/y always hold the pixel currently presented on the write port.
module fb_raster_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [X_W-1:0] x_lo,
  input  logic [X_W-1:0] x_hi,
  input  logic [Y_W-1:0] y_lo,
  input  logic [Y_W-1:0] y_hi,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_lo_r;
  logic [X_W-1:0] x_hi_r;
  logic [Y_W-1:0] y_hi_r;

  assign last = (x == x_hi_r) && (y == y_hi_r);

  // equality tests before incrementing keep the top edge from wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x      <= '0;
      y      <= '0;
      x_lo_r <= '0;
      x_hi_r <= '0;
      y_hi_r <= '0;
    end else begin
      unique case (1'b1)
        start: begin
          x      <= x_lo;
          y      <= y_lo;
          x_lo_r <= x_lo;
          x_hi_r <= x_hi;
          y_hi_r <= y_hi;
        end
        advance: begin
          if (x == x_hi_r) begin
            x <= x_lo_r;
            if (y != y_hi_r)
              y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fb_draw_engine.sv
// Framebuffer write-side producer: clears the back buffer on each
// frame switch, then rasterises queued solid rectangles.
module fb_draw_engine
  import fb_draw_pkg::*;
#(
  parameter int X_W      = FB_X_W,
  parameter int Y_W      = FB_Y_W,
  parameter int C_W      = FB_C_W,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           new_frame,
  input  logic [C_W-1:0] clear_color,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [X_W-1:0] cmd_x0,
  input  logic [Y_W-1:0] cmd_y0,
  input  logic [X_W-1:0] cmd_x1,
  input  logic [Y_W-1:0] cmd_y1,
  input  logic [C_W-1:0] cmd_color,
  output logic           we,
  output logic [X_W-1:0] wx,
  output logic [Y_W-1:0] wy,
  output logic [C_W-1:0] wc,
  output logic           busy,
  output logic           frame_overrun
);

  state_t         state;
  logic           last;
  logic           accept;
  logic           degen;
  logic           fill_go;
  logic           start;
  logic           advance;
  logic [X_W-1:0] lo_x;
  logic [X_W-1:0] hi_x;
  logic [Y_W-1:0] lo_y;
  logic [Y_W-1:0] hi_y;

  assign busy    = (state == S_CLEAR) || (state == S_FILL);
  // ready on the final pixel too, so commands chain without bubbles
  assign cmd_ready = ((state == S_IDLE) || (busy && last)) && !new_frame;
  assign accept  = cmd_valid && cmd_ready;
  assign degen   = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1);
  assign fill_go = accept && !degen;
  assign start   = (new_frame && CLEAR_EN) || fill_go;
  assign advance = busy && !last && !new_frame;

  assign lo_x = new_frame ? '0 : cmd_x0;
  assign hi_x = new_frame ? '1 : cmd_x1;
  assign lo_y = new_frame ? '0 : cmd_y0;
  assign hi_y = new_frame ? '1 : cmd_y1;

  fb_raster_counter #(
    .X_W(X_W),
    .Y_W(Y_W)
  ) u_raster (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x_lo   (lo_x),
    .x_hi   (hi_x),
    .y_lo   (lo_y),
    .y_hi   (hi_y),
    .advance(advance),
    .x      (wx),
    .y      (wy),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_WAIT_FRAME;
      we            <= 1'b0;
      wc            <= '0;
      frame_overrun <= 1'b0;
    end else begin
      frame_overrun <= new_frame && busy;
      unique case (1'b1)
        new_frame: begin
          state <= CLEAR_EN ? S_CLEAR : S_IDLE;
          we    <= CLEAR_EN;
          if (CLEAR_EN)
            wc <= clear_color;
        end
        fill_go: begin
          state <= S_FILL;
          we    <= 1'b1;
          wc    <= cmd_color;
        end
        advance: begin
          we <= 1'b1;
          if (state == S_CLEAR)
            wc <= clear_color;
        end
        default: begin
          we <= 1'b0;
          if (state != S_WAIT_FRAME)
            state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
